dmem_bus_arbiter: RTL and testbench

- Shares the single synchronous data-memory port between two requesters:
  - the CPU memory stage, which sits behind the byte-lane/sign-extension logic;
  - a secondary bus master (DMA/debug loader).
- The CPU has priority. When it loses the port, the block raises a pipeline `pause`.
- Returns read data to whichever requester issued the access one cycle earlier.
- Holds the CPU's last read word while the CPU is paused, so a stalled memory stage re-evaluates against stable data.

---
 rtl/dmem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// Shares the single synchronous data-memory port between the CPU memory stage and a DMA/debug master.
// Optional starvation guard is compiled in with `define DMEM_ARB_STARVE_EN.
module dmem_bus_arbiter #(
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [3:0]  cpu_wr_en,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_pause,
   input  logic        dma_req,
   input  logic [31:0] dma_addr,
   input  logic [3:0]  dma_wr_en,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dout,
   output logic [3:0]  mem_wr_en,
   input  logic [31:0] mem_din,
   output logic [1:0]  dbg_own_o
);

   typedef enum logic [1:0] {OWN_IDLE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} own_t;
   typedef enum logic [1:0] {RSEL_NONE = 2'd0, RSEL_CPU = 2'd1, RSEL_DMA = 2'd2} rsel_t;

   own_t        own_q, own_d;
   rsel_t       rsel_q, rsel_d;
   logic [31:0] cpu_rhold_q;
   logic        cpu_act, dma_act;
   logic        cpu_gnt, dma_gnt_w;
   logic        force_w;

   // Requests are ignored while reset is held so nothing reaches memory.
   assign cpu_act = cpu_req & ~rst;
   assign dma_act = dma_req & ~rst;

   assign dma_gnt_w = dma_act & (~cpu_act | force_w);
   assign cpu_gnt   = cpu_act & ~dma_gnt_w;

`ifdef DMEM_ARB_STARVE_EN
   localparam logic [3:0] LIM4 = STARVE_LIM[3:0];

   logic [3:0] stv_q, stv_d;
   logic       force_q, force_d;

   always_comb begin
      stv_d   = stv_q;
      force_d = force_q;
      if (dma_gnt_w || !dma_act) begin
         stv_d   = 4'd0;
         force_d = 1'b0;
      end else if (cpu_gnt) begin
         stv_d   = stv_q + 4'd1;
         force_d = ((stv_q + 4'd1) == LIM4);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stv_q   <= 4'd0;
         force_q <= 1'b0;
      end else begin
         stv_q   <= stv_d;
         force_q <= force_d;
      end
   end

   assign force_w = force_q;
`else
   assign force_w = 1'b0;
`endif

   always_comb begin
      mem_addr  = cpu_addr;
      mem_dout  = cpu_wdata;
      mem_wr_en = 4'b0000;
      own_d     = OWN_IDLE;
      rsel_d    = RSEL_NONE;
      if (dma_gnt_w) begin
         mem_addr  = dma_addr;
         mem_dout  = dma_wdata;
         mem_wr_en = dma_wr_en;
         own_d     = OWN_DMA;
         if (dma_wr_en == 4'b0000) rsel_d = RSEL_DMA;
      end else if (cpu_gnt) begin
         mem_wr_en = cpu_wr_en;
         own_d     = OWN_CPU;
         if (cpu_wr_en == 4'b0000) rsel_d = RSEL_CPU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own_q       <= OWN_IDLE;
         rsel_q      <= RSEL_NONE;
         cpu_rhold_q <= 32'd0;
      end else begin
         own_q  <= own_d;
         rsel_q <= rsel_d;
         if (rsel_q == RSEL_CPU) cpu_rhold_q <= mem_din;
      end
   end

   // A paused memory stage keeps seeing its last returned word.
   assign cpu_rdata  = (rsel_q == RSEL_CPU) ? mem_din : cpu_rhold_q;
   assign dma_rvalid = (rsel_q == RSEL_DMA);
   assign dma_rdata  = mem_din;
   assign dma_gnt    = dma_gnt_w;
   assign cpu_pause  = cpu_req & ~cpu_gnt;
   assign dbg_own_o  = own_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a behavioural arbitration model checked every cycle,
// plus literal expectations for the named scenarios. Honours DMEM_ARB_STARVE_EN like the design.
module tb_dmem_bus_arbiter;

   localparam int LIM = 4;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [3:0]  cpu_wr_en;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_pause;
   logic        dma_req;
   logic [31:0] dma_addr;
   logic [3:0]  dma_wr_en;
   logic [31:0] dma_wdata;
   logic        dma_gnt;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [3:0]  mem_wr_en;
   logic [31:0] mem_din;
   logic [1:0]  dbg_own;

   int n_vec = 0;
   int n_err = 0;

   dmem_bus_arbiter #(.STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_pause(cpu_pause),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wr_en(dma_wr_en), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr_en(mem_wr_en), .mem_din(mem_din),
      .dbg_own_o(dbg_own)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checkers ----------------
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_wins  = 0;   // CPU wins in a row while DMA waits
   bit          m_force = 1'b0;
   int          m_ret   = 0;   // 0: no read in flight, 1: CPU read, 2: DMA read
   logic [31:0] m_hold  = 32'd0;

   function automatic void model_grant(output bit gc, output bit gd);
      bit c, d;
      c  = cpu_req && !rst;
      d  = dma_req && !rst;
      gd = d && (!c || (STARVE && m_force));
      gc = c && !gd;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit gc, gd;
      if (rst) begin
         m_wins  <= 0;
         m_force <= 1'b0;
         m_ret   <= 0;
         m_hold  <= 32'd0;
      end else begin
         model_grant(gc, gd);
         if (m_ret == 1) m_hold <= mem_din;
         if (gc && cpu_wr_en == 4'b0000)      m_ret <= 1;
         else if (gd && dma_wr_en == 4'b0000) m_ret <= 2;
         else                                 m_ret <= 0;
         if (gd || !dma_req) begin
            m_wins  <= 0;
            m_force <= 1'b0;
         end else if (gc) begin
            m_wins <= m_wins + 1;
            if (m_wins + 1 >= LIM) m_force <= 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bit gc, gd;
      model_grant(gc, gd);
      check1("m_dma_gnt", dma_gnt, gd);
      check1("m_cpu_pause", cpu_pause, cpu_req && !gc);
      check32("m_mem_addr", mem_addr, gd ? dma_addr : cpu_addr);
      check32("m_mem_dout", mem_dout, gd ? dma_wdata : cpu_wdata);
      check32("m_mem_wr_en", {28'd0, mem_wr_en}, gd ? {28'd0, dma_wr_en} : gc ? {28'd0, cpu_wr_en} : 32'd0);
      check1("m_dma_rvalid", dma_rvalid, m_ret == 2);
      check32("m_cpu_rdata", cpu_rdata, (m_ret == 1) ? mem_din : m_hold);
      if (m_ret == 2) check32("m_dma_rdata", dma_rdata, mem_din);
   end

   // ---------------- driver ----------------
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      cpu_req = 1'b0; cpu_addr = 32'd0; cpu_wr_en = 4'd0; cpu_wdata = 32'd0;
      dma_req = 1'b1; dma_addr = 32'h40; dma_wr_en = 4'hF; dma_wdata = 32'hCAFEF00D;
      mem_din = 32'h0;
      #1 rst = 1'b1;

      // reset: requests are refused
      @(negedge clk);
      check1("rst_dma_gnt", dma_gnt, 1'b0);
      check32("rst_mem_wr_en", {28'd0, mem_wr_en}, 32'd0);
      check1("rst_dma_rvalid", dma_rvalid, 1'b0);
      check32("rst_cpu_rdata", cpu_rdata, 32'd0);
      next();
      rst = 1'b0; dma_req = 1'b0; dma_wr_en = 4'd0;

      // CPU-only read
      cpu_req = 1'b1; cpu_addr = 32'h100; cpu_wr_en = 4'd0;
      @(negedge clk);
      check32("cpu_rd_addr", mem_addr, 32'h100);
      check1("cpu_rd_pause", cpu_pause, 1'b0);
      next();
      cpu_req = 1'b0; mem_din = 32'hDEADBEEF;
      @(negedge clk);
      check32("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);

      // DMA-only write
      next();
      mem_din = 32'h0;
      dma_req = 1'b1; dma_addr = 32'h200; dma_wr_en = 4'hF; dma_wdata = 32'h12345678;
      @(negedge clk);
      check1("dma_wr_gnt", dma_gnt, 1'b1);
      check32("dma_wr_en", {28'd0, mem_wr_en}, 32'hF);
      check32("dma_wr_dout", mem_dout, 32'h12345678);

      // DMA-only read, CPU data must hold
      next();
      dma_addr = 32'h300; dma_wr_en = 4'd0;
      @(negedge clk);
      check1("dma_rd_gnt", dma_gnt, 1'b1);
      next();
      dma_req = 1'b0; mem_din = 32'h0BADF00D;
      @(negedge clk);
      check1("dma_rd_rvalid", dma_rvalid, 1'b1);
      check32("dma_rd_data", dma_rdata, 32'h0BADF00D);
      check32("dma_rd_cpu_hold", cpu_rdata, 32'hDEADBEEF);

      // CPU partial write
      next();
      cpu_req = 1'b1; cpu_addr = 32'h104; cpu_wr_en = 4'b0011; cpu_wdata = 32'hA5A5A5A5;
      mem_din = $urandom;
      @(negedge clk);
      check32("cpu_wr_en", {28'd0, mem_wr_en}, 32'h3);
      check32("cpu_wr_dout", mem_dout, 32'hA5A5A5A5);
      next();
      cpu_req = 1'b0; cpu_wr_en = 4'd0; mem_din = $urandom;
      @(negedge clk);
      check1("cpu_wr_no_rvalid", dma_rvalid, 1'b0);
      check32("cpu_wr_hold", cpu_rdata, 32'hDEADBEEF);

      // back-to-back alternating reads
      for (int i = 0; i < 8; i++) begin
         next();
         cpu_req = (i % 2 == 0); dma_req = (i % 2 == 1);
         cpu_addr = 32'h1000 + 4 * i; dma_addr = 32'h2000 + 4 * i;
         mem_din = $urandom;
         @(negedge clk);
         check1($sformatf("alt_gnt_%0d", i), dma_gnt, (i % 2 == 1));
      end

`ifdef DMEM_ARB_STARVE_EN
      // contention: CPU wins LIM cycles, DMA forced one; read hold across the pause
      for (int i = 0; i < 10; i++) begin
         next();
         cpu_req = 1'b1; cpu_wr_en = 4'd0; cpu_addr = 32'h400 + 4 * i;
         dma_req = 1'b1; dma_wr_en = 4'd0; dma_addr = 32'h800 + 4 * i;
         mem_din = (i == 4) ? 32'hAAAA0001 : (i == 5) ? 32'h5555FFFF : $urandom;
         @(negedge clk);
         check1($sformatf("cont_gnt_%0d", i), dma_gnt, (i % 5) == 4);
         check1($sformatf("cont_pause_%0d", i), cpu_pause, (i % 5) == 4);
         if (i == 4) check32("hold_cpu_ret", cpu_rdata, 32'hAAAA0001);
         if (i == 5) begin
            check32("hold_cpu_stable", cpu_rdata, 32'hAAAA0001);
            check1("hold_dma_rvalid", dma_rvalid, 1'b1);
            check32("hold_dma_rdata", dma_rdata, 32'h5555FFFF);
         end
      end
`else
      // strict priority: DMA waits while the CPU requests
      for (int i = 0; i < 20; i++) begin
         next();
         cpu_req = 1'b1; cpu_wr_en = 4'd0; cpu_addr = 32'h400 + 4 * i;
         dma_req = 1'b1; dma_wr_en = 4'd0; dma_addr = 32'h800;
         mem_din = $urandom;
         @(negedge clk);
         check1($sformatf("prio_gnt_%0d", i), dma_gnt, 1'b0);
         check1($sformatf("prio_pause_%0d", i), cpu_pause, 1'b0);
      end
      next();
      cpu_req = 1'b0; mem_din = $urandom;
      @(negedge clk);
      check1("prio_release_gnt", dma_gnt, 1'b1);
`endif

      // reset asserted mid-access
      next();
      dma_req = 1'b0; cpu_req = 1'b1; cpu_wr_en = 4'd0; cpu_addr = 32'h500; mem_din = $urandom;
      next();
      cpu_req = 1'b0; dma_req = 1'b1; dma_wr_en = 4'hF; dma_addr = 32'h600; mem_din = 32'h11112222;
      #1;
      check32("pre_rst_cpu_rdata", cpu_rdata, 32'h11112222);
      check1("pre_rst_dma_gnt", dma_gnt, 1'b1);
      #1 rst = 1'b1;
      #1;
      check1("mid_rst_dma_gnt", dma_gnt, 1'b0);
      check32("mid_rst_mem_wr_en", {28'd0, mem_wr_en}, 32'd0);
      check1("mid_rst_dma_rvalid", dma_rvalid, 1'b0);
      check32("mid_rst_cpu_rdata", cpu_rdata, 32'd0);
      next();
      rst = 1'b0; dma_req = 1'b0; mem_din = $urandom;
      @(negedge clk);
      check1("post_rst_rvalid", dma_rvalid, 1'b0);
      check32("post_rst_cpu_rdata", cpu_rdata, 32'd0);
      next();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
